// File: rtl/inst_enc_if.sv
// inst_enc_if: command port and instruction-word port of the instruction encoder.
// master = command producer / decode-side consumer, slave = the encoder itself.
interface inst_enc_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_imm;
  logic [11:0] cmd_csr;
  logic        cmd_last;
  logic        cmd_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_size, cmd_imm,
           cmd_csr, cmd_last, inst_ready,
    input  cmd_ready, cmd_err, inst_valid, inst
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_size, cmd_imm,
           cmd_csr, cmd_last, inst_ready,
    output cmd_ready, cmd_err, inst_valid, inst
  );
endinterface

// File: rtl/inst_enc.sv
// inst_enc: encodes abstract commands into RV64I/Zicsr instruction words,
// expands LI32 into LUI+ADDIW when the constant does not fit 12 bits, and
// queues the words in a DEPTH-entry FIFO feeding the decode stage.
// Optional feature macro: INST_ENC_EBREAK_TAIL_EN appends an EBREAK after
// the last word of a command latched with cmd_last=1.
module inst_enc #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  inst_enc_if.slave bus,
  output logic      busy
);
  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);

  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [3:0] OP_ADDI    = 4'd0;
  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [3:0] OP_LOAD    = 4'd2;
  localparam logic [3:0] OP_STORE   = 4'd3;
  localparam logic [3:0] OP_CSRRW   = 4'd4;
  localparam logic [3:0] OP_CSRRS   = 4'd5;
  localparam logic [3:0] OP_LI32    = 4'd6;
  localparam logic [3:0] OP_EBREAK  = 4'd7;
  localparam logic [3:0] OP_FENCE_I = 4'd8;

  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_REG    = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_IMMW   = 7'h1B;

  localparam logic [DATA_W-1:0] EBREAK_W  = 32'h0010_0073;
  localparam logic [DATA_W-1:0] FENCEI_W  = 32'h0000_100F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
`ifdef INST_ENC_EBREAK_TAIL_EN
    , TAIL = 2'd3
`endif
  } state_t;

  // Illegal ops and stores with an out-of-range access size are dropped.
  function automatic logic is_illegal(input logic [3:0] op, input logic [2:0] size);
    return (op > OP_FENCE_I) || ((op == OP_STORE) && size[2]);
  endfunction

  // A 32-bit constant fits a single ADDI when bits 31..11 are a sign extension.
  function automatic logic li32_short(input logic [31:0] imm);
    return (&imm[31:11]) || (~|imm[31:11]);
  endfunction

  function automatic logic [DATA_W-1:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                             input logic [2:0] f3, input logic [4:0] rd,
                                             input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [DATA_W-1:0] enc_word0(input logic [3:0]  op,
                                                 input logic [4:0]  rd,
                                                 input logic [4:0]  rs1,
                                                 input logic [4:0]  rs2,
                                                 input logic [2:0]  size,
                                                 input logic [31:0] imm,
                                                 input logic [11:0] csr);
    logic [19:0] hi;
    // Upper part pre-compensated for the sign of the low 12 bits, wrapping mod 2^20.
    hi = imm[31:12] + {19'd0, imm[11]};
    case (op)
      OP_ADDI:    enc_word0 = enc_i(imm[11:0], rs1, 3'b000, rd, OPC_IMM);
      OP_ADD:     enc_word0 = {7'd0, rs2, rs1, 3'b000, rd, OPC_REG};
      OP_LOAD:    enc_word0 = enc_i(imm[11:0], rs1, size, rd, OPC_LOAD);
      OP_STORE:   enc_word0 = {imm[11:5], rs2, rs1, size, imm[4:0], OPC_STORE};
      OP_CSRRW:   enc_word0 = enc_i(csr, rs1, 3'b001, rd, OPC_SYSTEM);
      OP_CSRRS:   enc_word0 = enc_i(csr, rs1, 3'b010, rd, OPC_SYSTEM);
      OP_LI32:    enc_word0 = li32_short(imm) ? enc_i(imm[11:0], 5'd0, 3'b000, rd, OPC_IMM)
                                              : {hi, rd, OPC_LUI};
      OP_EBREAK:  enc_word0 = EBREAK_W;
      OP_FENCE_I: enc_word0 = FENCEI_W;
      default:    enc_word0 = '0;
    endcase
  endfunction

  state_t            state;
  state_t            fin_state;
  logic [3:0]        op_p0;
  logic [4:0]        rd_p0;
  logic [4:0]        rs1_p0;
  logic [4:0]        rs2_p0;
  logic [2:0]        size_p0;
  logic [31:0]       imm_p0;
  logic [11:0]       csr_p0;
  logic              err_p0;
  logic [DATA_W-1:0] word0;
  logic [DATA_W-1:0] word1;
  logic [DATA_W-1:0] push_word;
  logic              two_words;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  assign accept = bus.cmd_valid && (state == IDLE) && !flush;
  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign push   = (state != IDLE) && !full && !flush;
  assign pop    = !empty && bus.inst_ready && !flush;

`ifdef INST_ENC_EBREAK_TAIL_EN
  logic last_p0;

  // After the final word, a command marked last detours through TAIL.
  always_comb begin
    fin_state = IDLE;
    if (last_p0) fin_state = TAIL;
  end
`else
  logic unused_last;
  assign unused_last = bus.cmd_last;

  // Without the tail feature every command returns straight to IDLE.
  always_comb begin
    fin_state = IDLE;
  end
`endif

  // Stage p0: command fields held for the duration of the expansion.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= bus.cmd_op;
      rd_p0   <= bus.cmd_rd;
      rs1_p0  <= bus.cmd_rs1;
      rs2_p0  <= bus.cmd_rs2;
      size_p0 <= bus.cmd_size;
      imm_p0  <= bus.cmd_imm;
      csr_p0  <= bus.cmd_csr;
`ifdef INST_ENC_EBREAK_TAIL_EN
      last_p0 <= bus.cmd_last;
`endif
    end
  end

  // Encode the words of the held command and select the one for this state.
  always_comb begin
    word0     = enc_word0(op_p0, rd_p0, rs1_p0, rs2_p0, size_p0, imm_p0, csr_p0);
    word1     = enc_i(imm_p0[11:0], rd_p0, 3'b000, rd_p0, OPC_IMMW);
    two_words = (op_p0 == OP_LI32) && !li32_short(imm_p0);
    push_word = word0;
    case (state)
      EMIT1:   push_word = word1;
`ifdef INST_ENC_EBREAK_TAIL_EN
      TAIL:    push_word = EBREAK_W;
`endif
      default: push_word = word0;
    endcase
  end

  // Sequencer: advances one word per push, holds while the FIFO is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      err_p0 <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      err_p0 <= 1'b0;
    end else begin
      err_p0 <= accept && is_illegal(bus.cmd_op, bus.cmd_size);
      case (state)
        IDLE:    if (accept && !is_illegal(bus.cmd_op, bus.cmd_size)) state <= EMIT0;
        EMIT0:   if (!full) state <= two_words ? EMIT1 : fin_state;
        EMIT1:   if (!full) state <= fin_state;
`ifdef INST_ENC_EBREAK_TAIL_EN
        TAIL:    if (!full) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: FIFO storage, written on push only.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.cmd_err    = err_p0;
  assign bus.inst_valid = !empty;
  assign bus.inst       = empty ? '0 : mem[rd_ptr];
  assign busy           = (state != IDLE) || !empty;
endmodule

// File: tb/tb_inst_enc.sv
// tb_inst_enc: table-driven vectors, hand-written multi-cycle sequences and a
// randomized run checked against an arithmetic reference model.
module tb_inst_enc;
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  size;
    logic [31:0] imm;
    logic [11:0] csr;
    logic        last;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          err;
  } vec_t;

`ifdef INST_ENC_EBREAK_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  always #5 clk = ~clk;

  inst_enc_if bus ();
  inst_enc #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy));

  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_cnt  = 0;
  int          exp_err  = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  bit          rand_done;

  // Monitor: record every word that leaves the FIFO and every error cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n && !flush) begin
      if (bus.inst_valid && bus.inst_ready) got_q.push_back(bus.inst);
      if (bus.cmd_err) err_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare_q(input string name, input logic [31:0] exp[$]);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_w%0d", name, i), (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, exp[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] size,
                              input logic [31:0] imm, input logic [11:0] csr);
    cmd_t c;
    c.op = op; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2; c.size = size;
    c.imm = imm; c.csr = csr; c.last = 1'b0;
    return c;
  endfunction

  task automatic send_cmd(input cmd_t c);
    int w = 0;
    while (!bus.cmd_ready && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready stayed 0 for %0d cycles", w);
    end
    bus.cmd_op = c.op; bus.cmd_rd = c.rd; bus.cmd_rs1 = c.rs1; bus.cmd_rs2 = c.rs2;
    bus.cmd_size = c.size; bus.cmd_imm = c.imm; bus.cmd_csr = c.csr; bus.cmd_last = c.last;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    while ((busy || bus.inst_valid) && w < budget) begin
      tick();
      w++;
    end
    if (w >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles", w);
    end
  endtask

  // Reference model: RISC-V field placement by shifts, LI32 split by value range.
  task automatic model_push(input cmd_t c);
    logic [31:0] rd  = 32'(c.rd) << 7;
    logic [31:0] rs1 = 32'(c.rs1) << 15;
    logic [31:0] rs2 = 32'(c.rs2) << 20;
    logic [31:0] f3  = 32'(c.size) << 12;
    logic [31:0] i12 = (c.imm & 32'hFFF) << 20;
    logic [31:0] hi;
    bit ill = (c.op > 8) || (c.op == 3 && c.size >= 4);
    if (ill) begin
      exp_err++;
      return;
    end
    case (c.op)
      0: exp_q.push_back(i12 | rs1 | rd | 32'h13);
      1: exp_q.push_back(rs2 | rs1 | rd | 32'h33);
      2: exp_q.push_back(i12 | rs1 | f3 | rd | 32'h03);
      3: exp_q.push_back((((c.imm >> 5) & 32'h7F) << 25) | rs2 | rs1 | f3 | ((c.imm & 32'h1F) << 7) | 32'h23);
      4: exp_q.push_back((32'(c.csr) << 20) | rs1 | (32'd1 << 12) | rd | 32'h73);
      5: exp_q.push_back((32'(c.csr) << 20) | rs1 | (32'd2 << 12) | rd | 32'h73);
      6: begin
        if ($signed(c.imm) >= -2048 && $signed(c.imm) <= 2047) begin
          exp_q.push_back(i12 | rd | 32'h13);
        end else begin
          hi = (c.imm + 32'h800) >> 12;
          exp_q.push_back((hi << 12) | rd | 32'h37);
          exp_q.push_back(i12 | (32'(c.rd) << 15) | rd | 32'h1B);
        end
      end
      7: exp_q.push_back(32'h0010_0073);
      default: exp_q.push_back(32'h0000_100F);
    endcase
    if (TAIL_EN && c.last) exp_q.push_back(32'h0010_0073);
  endtask

  vec_t        vt[14];
  logic [31:0] eq[$];
  cmd_t        cc;

  initial begin
    rst_n = 1'b1; flush = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
    bus.cmd_size = '0; bus.cmd_imm = '0; bus.cmd_csr = '0; bus.cmd_last = 1'b0;
    bus.inst_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Latency of a single-word command.
    bus.inst_ready = 1'b1;
    got_q.delete();
    send_cmd(mk(4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 12'd0));
    check("lat_valid_e", 32'(bus.inst_valid), 32'd0);
    check("lat_busy_e", 32'(busy), 32'd1);
    tick();
    check("lat_valid_e1", 32'(bus.inst_valid), 32'd1);
    check("lat_inst_e1", bus.inst, 32'h0050_0093);
    tick();
    check("lat_valid_e2", 32'(bus.inst_valid), 32'd0);
    check("lat_busy_e2", 32'(busy), 32'd0);

    // Table of single commands with hand-computed encodings.
    vt[0]  = '{mk(4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 12'd0), 1, 32'h0050_0093, 32'h0, 0};
    vt[1]  = '{mk(4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5678, 12'd0), 2, 32'h1234_52B7, 32'h6782_829B, 0};
    vt[2]  = '{mk(4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_0FFF, 12'd0), 2, 32'h0000_12B7, 32'hFFF2_829B, 0};
    vt[3]  = '{mk(4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800, 12'd0), 1, 32'h8000_0293, 32'h0, 0};
    vt[4]  = '{mk(4'd5, 5'd10, 5'd0, 5'd0, 3'd0, 32'd0, 12'h300), 1, 32'h3000_2573, 32'h0, 0};
    vt[5]  = '{mk(4'd3, 5'd0, 5'd3, 5'd2, 3'd3, 32'd8, 12'd0), 1, 32'h0021_B423, 32'h0, 0};
    vt[6]  = '{mk(4'd2, 5'd7, 5'd2, 5'd0, 3'd3, 32'h10, 12'd0), 1, 32'h0101_3383, 32'h0, 0};
    vt[7]  = '{mk(4'd4, 5'd0, 5'd5, 5'd0, 3'd0, 32'd0, 12'h305), 1, 32'h3052_9073, 32'h0, 0};
    vt[8]  = '{mk(4'd0, 5'd2, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFF0, 12'd0), 1, 32'hFF01_0113, 32'h0, 0};
    vt[9]  = '{mk(4'd6, 5'd6, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 12'd0), 2, 32'h0000_1337, 32'h8003_031B, 0};
    vt[10] = '{mk(4'd7, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 12'd0), 1, 32'h0010_0073, 32'h0, 0};
    vt[11] = '{mk(4'd8, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 12'd0), 1, 32'h0000_100F, 32'h0, 0};
    vt[12] = '{mk(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 32'd1, 12'd0), 0, 32'h0, 32'h0, 1};
    vt[13] = '{mk(4'd3, 5'd0, 5'd3, 5'd2, 3'd4, 32'd8, 12'd0), 0, 32'h0, 32'h0, 1};
    for (int i = 0; i < 14; i++) begin
      got_q.delete();
      err_cnt = 0;
      eq.delete();
      if (vt[i].n > 0) eq.push_back(vt[i].w0);
      if (vt[i].n > 1) eq.push_back(vt[i].w1);
      send_cmd(vt[i].c);
      repeat (8) tick();
      compare_q($sformatf("vec%0d", i), eq);
      check($sformatf("vec%0d_err", i), 32'(err_cnt), 32'(vt[i].err));
    end

    // ADD marked last: tail EBREAK only when the feature is built in.
    got_q.delete();
    eq.delete();
    cc = mk(4'd1, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 12'd0);
    cc.last = 1'b1;
    eq.push_back(32'h0031_00B3);
    if (TAIL_EN) eq.push_back(32'h0010_0073);
    send_cmd(cc);
    repeat (8) tick();
    compare_q("tail", eq);

    // Backpressure: three two-word LI32 commands into a 4-entry FIFO.
    bus.inst_ready = 1'b0;
    got_q.delete();
    send_cmd(mk(4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5678, 12'd0));
    send_cmd(mk(4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_0FFF, 12'd0));
    send_cmd(mk(4'd6, 5'd7, 5'd0, 5'd0, 3'd0, 32'hDEAD_BEEF, 12'd0));
    repeat (6) tick();
    check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_head", bus.inst, 32'h1234_52B7);
    check("bp_popped", 32'(got_q.size()), 32'd0);
    bus.inst_ready = 1'b1;
    wait_idle(100);
    eq = '{32'h1234_52B7, 32'h6782_829B, 32'h0000_12B7, 32'hFFF2_829B, 32'hDEAD_C3B7, 32'hEEF3_839B};
    compare_q("bp", eq);

    // Flush in the middle of an LI32 expansion.
    bus.inst_ready = 1'b0;
    send_cmd(mk(4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5678, 12'd0));
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("fl_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("fl_inst", bus.inst, 32'd0);
    repeat (3) tick();
    check("fl_busy_after", 32'(busy), 32'd0);
    check("fl_valid_after", 32'(bus.inst_valid), 32'd0);

    // A command offered during flush is dropped.
    bus.cmd_op = 4'd0; bus.cmd_rd = 5'd1; bus.cmd_imm = 32'd5; bus.cmd_valid = 1'b1;
    flush = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    flush = 1'b0;
    repeat (3) tick();
    check("fl_cmd_dropped", 32'(bus.inst_valid), 32'd0);

    // Asynchronous reset in the middle of an LI32 expansion.
    send_cmd(mk(4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5678, 12'd0));
    tick();
    rst_n = 1'b0;
    #1;
    check("ar_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("ar_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("ar_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized commands with random backpressure against the model.
    got_q.delete();
    exp_q.delete();
    err_cnt = 0;
    exp_err = 0;
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          cc.op   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
          cc.rd   = 5'($urandom);
          cc.rs1  = 5'($urandom);
          cc.rs2  = 5'($urandom);
          cc.size = 3'($urandom);
          cc.imm  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'($urandom_range(0, 4095)) - 32'd2048);
          cc.csr  = 12'($urandom);
          cc.last = 1'($urandom);
          model_push(cc);
          send_cmd(cc);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          bus.inst_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.inst_ready = 1'b1;
    wait_idle(500);
    repeat (2) tick();
    compare_q("rand", exp_q);
    check("rand_err_count", 32'(err_cnt), 32'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
